// File: rtl/display_scheduler_if.sv
// rtl/display_scheduler_if.sv - scan/request inputs and display outputs of the display scheduler
interface display_scheduler_if;
  logic        scan_tick;
  logic [15:0] digits;
  logic [3:0]  digit_en;
  logic [2:0]  msg_req;
  logic [3:0]  AN;
  logic [6:0]  seven_out;
  logic        msg_active;
  logic [1:0]  msg_id;

  modport master (
    output scan_tick, digits, digit_en, msg_req,
    input  AN, seven_out, msg_active, msg_id
  );

  modport slave (
    input  scan_tick, digits, digit_en, msg_req,
    output AN, seven_out, msg_active, msg_id
  );
endinterface

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - 4-digit seven-segment scanner with priority-held status messages
module display_scheduler #(
  parameter int HOLD_TICKS = 1000
) (
  input logic               clk,
  input logic               rst,
  display_scheduler_if.slave bus
);
  localparam int CW = $clog2(HOLD_TICKS + 1);

  typedef enum logic {SCAN, MSG} state_t;

  state_t          state;
  logic [1:0]      idx;
  logic [CW-1:0]   hold_cnt;
  logic [1:0]      winner;
  logic [3:0]      nib;
  logic [6:0]      glyph;

  function automatic logic [6:0] hex_font(input logic [3:0] v);
    case (v)
      4'h0: hex_font = 7'h40;  4'h1: hex_font = 7'h79;
      4'h2: hex_font = 7'h24;  4'h3: hex_font = 7'h30;
      4'h4: hex_font = 7'h19;  4'h5: hex_font = 7'h12;
      4'h6: hex_font = 7'h02;  4'h7: hex_font = 7'h78;
      4'h8: hex_font = 7'h00;  4'h9: hex_font = 7'h10;
      4'hA: hex_font = 7'h08;  4'hB: hex_font = 7'h03;
      4'hC: hex_font = 7'h46;  4'hD: hex_font = 7'h21;
      4'hE: hex_font = 7'h06;  default: hex_font = 7'h0E;
    endcase
  endfunction

  // pos 3 is the leftmost digit (AN[3])
  function automatic logic [6:0] msg_glyph(input logic [1:0] id, input logic [1:0] pos);
    case ({id, pos})
      4'b01_11: msg_glyph = 7'h40;  4'b01_10: msg_glyph = 7'h0C;
      4'b01_01: msg_glyph = 7'h06;  4'b01_00: msg_glyph = 7'h2B;
      4'b10_11: msg_glyph = 7'h06;  4'b10_10: msg_glyph = 7'h2F;
      4'b10_01: msg_glyph = 7'h2F;  4'b11_11: msg_glyph = 7'h47;
      4'b11_10: msg_glyph = 7'h40;  4'b11_01: msg_glyph = 7'h46;
      4'b11_00: msg_glyph = 7'h21;  default:  msg_glyph = 7'h7F;
    endcase
  endfunction

  always_comb begin
    winner = 2'd0;
    if (bus.msg_req[2])      winner = 2'd3;
    else if (bus.msg_req[1]) winner = 2'd2;
    else if (bus.msg_req[0]) winner = 2'd1;
  end

  always_comb begin
    nib   = bus.digits[idx*4 +: 4];
    glyph = 7'h7F;
    if (state == MSG)              glyph = msg_glyph(bus.msg_id, idx);
    else if (bus.digit_en[idx])    glyph = hex_font(nib);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= SCAN;
      idx            <= 2'd0;
      hold_cnt       <= '0;
      bus.AN         <= 4'b1111;
      bus.seven_out  <= 7'h7F;
      bus.msg_active <= 1'b0;
      bus.msg_id     <= 2'd0;
    end else begin
      if (bus.scan_tick) idx <= idx + 2'd1;
      bus.AN        <= ~(4'b0001 << idx);
      bus.seven_out <= glyph;
      case (state)
        SCAN: begin
          if (winner != 2'd0) begin
            state          <= MSG;
            bus.msg_id     <= winner;
            bus.msg_active <= 1'b1;
            hold_cnt       <= '0;
          end
        end
        MSG: begin
          // an equal-or-higher request beats a simultaneous expiring tick
          if (winner != 2'd0 && winner >= bus.msg_id) begin
            bus.msg_id <= winner;
            hold_cnt   <= '0;
          end else if (bus.scan_tick) begin
            if (hold_cnt == CW'(HOLD_TICKS - 1)) begin
              state          <= SCAN;
              bus.msg_active <= 1'b0;
              hold_cnt       <= '0;
            end else begin
              hold_cnt <= hold_cnt + CW'(1);
            end
          end
        end
      endcase
    end
  end
endmodule
